// File: rtl/ssd1306_spi_rx.sv
// SSD1306 4-wire SPI responder: mode-0 byte receiver plus command-subset decoder.
// Optional debug LEDs: define SSD1306_RX_DEBUG_LED_EN.
module ssd1306_spi_rx #(
  parameter int          SYNC_STAGES    = 2,
  parameter logic [7:0]  CONTRAST_RESET = 8'h7F,
  parameter int          DATA_CNT_WIDTH = 16
) (
  input  logic                      clk_50M,
  input  logic                      rst_n,
  input  logic                      oled_sclk,
  input  logic                      oled_sdin,
  input  logic                      ss,
  input  logic                      oled_dc,
  input  logic                      oled_res,
  output logic [7:0]                rx_byte,
  output logic                      rx_valid,
  output logic                      rx_is_data,
  output logic                      display_on,
  output logic                      inverted,
  output logic                      all_on,
  output logic [7:0]                contrast,
  output logic                      charge_pump,
  output logic                      cmd_error,
  output logic [DATA_CNT_WIDTH-1:0] data_count,
  output logic [3:0]                led
);

  typedef enum logic {IDLE, ARG} state_e;

  // Lane order {res, dc, ss, sdin, sclk}; ss idles high.
  localparam logic [4:0] SYNC_RST = 5'b00100;

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [4:0] pins_s;
  logic       sclk_s, sdin_s, ss_s, dc_s, res_s;
  logic       sclk_prev_q, sclk_rise;

  logic [6:0] shreg_q;
  logic [2:0] bitcnt_q;
  logic [7:0] rx_byte_q;
  logic       rx_valid_q, rx_is_data_q;

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic       disp_q, disp_d;
  logic       inv_q, inv_d;
  logic       allon_q, allon_d;
  logic [7:0] contr_q, contr_d;
  logic       cp_q, cp_d;
  logic       err_q, err_d;
  logic [DATA_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic       is_arg, is_nop, is_flag;

  assign pins_s = sync_q[SYNC_STAGES-1];
  assign sclk_s = pins_s[0];
  assign sdin_s = pins_s[1];
  assign ss_s   = pins_s[2];
  assign dc_s   = pins_s[3];
  assign res_s  = pins_s[4];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= {SYNC_STAGES{SYNC_RST}};
      sclk_prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0],
                 {oled_res, oled_dc, ss, oled_sdin, oled_sclk}};
      sclk_prev_q <= sclk_s;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_is_data_q <= 1'b0;
    end else if (!res_s) begin
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_is_data_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (ss_s) begin
        bitcnt_q <= '0;
      end else if (sclk_rise) begin
        shreg_q  <= {shreg_q[5:0], sdin_s};
        bitcnt_q <= bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          rx_byte_q    <= {shreg_q, sdin_s};
          rx_is_data_q <= dc_s;
          rx_valid_q   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    is_arg  = rx_byte_q inside {8'h81, 8'h8D, 8'h20, 8'hA8, 8'hD3,
                                8'hD5, 8'hD9, 8'hDA, 8'hDB};
    is_nop  = (rx_byte_q < 8'h80) ||
              (rx_byte_q inside {8'hA0, 8'hA1, 8'hC0, 8'hC8, 8'hE3});
    is_flag = rx_byte_q inside {8'hAE, 8'hAF, 8'hA4, 8'hA5,
                                8'hA6, 8'hA7};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    disp_d  = disp_q;
    inv_d   = inv_q;
    allon_d = allon_q;
    contr_d = contr_q;
    cp_d    = cp_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (rx_valid_q) begin
      if (rx_is_data_q) begin
        cnt_d   = cnt_q + 1'b1;
        err_d   = (state_q == ARG);
        state_d = IDLE;
      end else if (state_q == ARG) begin
        if (op_q == 8'h81) contr_d = rx_byte_q;
        if (op_q == 8'h8D) cp_d = rx_byte_q[2];
        state_d = IDLE;
      end else begin
        unique case (1'b1)
          is_flag: begin
            if (rx_byte_q[7:1] == 7'h57) disp_d  = rx_byte_q[0];
            if (rx_byte_q[7:1] == 7'h52) allon_d = rx_byte_q[0];
            if (rx_byte_q[7:1] == 7'h53) inv_d   = rx_byte_q[0];
          end
          is_arg: begin
            op_d    = rx_byte_q;
            state_d = ARG;
          end
          is_nop:  ;
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      disp_q  <= 1'b0;
      inv_q   <= 1'b0;
      allon_q <= 1'b0;
      contr_q <= CONTRAST_RESET;
      cp_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (!res_s) begin
      state_q <= IDLE;
      op_q    <= '0;
      disp_q  <= 1'b0;
      inv_q   <= 1'b0;
      allon_q <= 1'b0;
      contr_q <= CONTRAST_RESET;
      cp_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      disp_q  <= disp_d;
      inv_q   <= inv_d;
      allon_q <= allon_d;
      contr_q <= contr_d;
      cp_q    <= cp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SSD1306_RX_DEBUG_LED_EN
  logic sticky_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n)      sticky_q <= 1'b0;
    else if (!res_s) sticky_q <= 1'b0;
    else if (err_d)  sticky_q <= 1'b1;
  end

  assign led = ~{disp_q, inv_q, sticky_q, rx_is_data_q};
`else
  assign led = 4'hF;
`endif

  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign rx_is_data  = rx_is_data_q;
  assign display_on  = disp_q;
  assign inverted    = inv_q;
  assign all_on      = allon_q;
  assign contrast    = contr_q;
  assign charge_pump = cp_q;
  assign cmd_error   = err_q;
  assign data_count  = cnt_q;

endmodule
